// File: rtl/alu_pipe_if.sv
// Operand-issue and result handshake bundle for alu_pipe.
// The WIDTH given here must match the WIDTH of the alu_pipe it is connected to.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [SHW-1:0]   shamt;
  logic [4:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, A, B, cin, shamt, opcode, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero, busy
  );

  modport slave (
    input  in_valid, A, B, cin, shamt, opcode, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, an iterative shift-add multiplier
// and synchronous flush; results are held until the consumer accepts them.
module alu_pipe #(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_pipe_if.slave bus
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_ROTL  = 5'd8,
    OP_ROTR  = 5'd9,
    OP_SLT   = 5'd10,
    OP_SLTU  = 5'd11,
    OP_MUL   = 5'd12,
    OP_MULHU = 5'd13
  } opcode_t;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  state_t           state_q, state_d;
  opcode_t          op;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic             accept, is_mul, mul_done, load_alu;

  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] prod_q, prod_step;
  logic [WIDTH-1:0]   mcand_q;
  logic               mulhu_q;
  logic [WIDTH:0]     mul_hi_sum;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] alu_res, next_res;
  logic             alu_c, alu_v, next_c, next_v;

  logic             out_valid_q, carry_q, ovf_q, zero_q;
  logic [WIDTH-1:0] result_q;

  assign op       = opcode_t'(bus.opcode);
  assign a        = bus.A;
  assign b        = bus.B;
  assign shamt    = bus.shamt;
  assign is_mul   = (op == OP_MUL) || (op == OP_MULHU);
  assign accept   = bus.in_valid && bus.in_ready;
  assign load_alu = accept && !is_mul;
  assign mul_done = (state_q == MUL_BUSY) && (cnt_q == SHW'(WIDTH - 1));

  assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !flush;
  assign bus.busy      = (state_q == MUL_BUSY);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carryout  = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // One multiplier bit per cycle: the low half of prod_q starts as B and is
  // shifted out while partial products accumulate into the high half.
  assign mul_hi_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step  = {mul_hi_sum, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      mulhu_q <= 1'b0;
    end else if (accept && is_mul) begin
      cnt_q   <= '0;
      prod_q  <= {{WIDTH{1'b0}}, b};
      mcand_q <= a;
      mulhu_q <= (op == OP_MULHU);
    end else if (state_q == MUL_BUSY) begin
      cnt_q   <= cnt_q + 1'b1;
      prod_q  <= prod_step;
    end
  end

  assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bus.cin};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_ROTL: alu_res = (a << shamt) | (a >> (WIDTH - int'(shamt)));
      OP_ROTR: alu_res = (a >> shamt) | (a << (WIDTH - int'(shamt)));
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    next_res = alu_res;
    next_c   = alu_c;
    next_v   = alu_v;
    if (mul_done) begin
      next_res = mulhu_q ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
      next_c   = 1'b0;
      next_v   = !mulhu_q && (prod_step[2*WIDTH-1:WIDTH] != '0);
    end
  end

  // Flush drops the valid but leaves the last result and flags visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_alu || mul_done) begin
      out_valid_q <= 1'b1;
      result_q    <= next_res;
      carry_q     <= next_c;
      ovf_q       <= next_v;
      zero_q      <= (next_res == '0);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: one 32-bit and one 8-bit instance, directed vectors,
// multi-cycle corner sequences and a randomized scoreboard run against a model.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    int          sel;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [4:0]  sh;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush32, flush8;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32)) bus32 ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush32), .bus(bus32));
  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .flush(flush8),  .bus(bus8));

  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t pend32, pend8;
  logic acc32, acc8;
  vec_t tv[$];

  function automatic exp_t mk(input logic [31:0] r, input logic c, input logic v, input logic z);
    return {r, c, v, z};
  endfunction

  // Independent width-generic reference computed in 64-bit arithmetic.
  function automatic exp_t refModel(input int w, input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic ci, input logic [4:0] sh);
    logic [63:0] m, aa, bb, s, p;
    longint      sa, sb;
    logic [31:0] r;
    logic        c, v;
    int          msb;
    m   = (64'd1 << w) - 64'd1;
    msb = w - 1;
    aa  = {32'h0, a} & m;
    bb  = {32'h0, b} & m;
    s   = 64'd0;
    p   = aa * bb;
    r   = 32'h0;
    c   = 1'b0;
    v   = 1'b0;
    sa  = aa[msb] ? longint'(aa) - longint'(m) - 1 : longint'(aa);
    sb  = bb[msb] ? longint'(bb) - longint'(m) - 1 : longint'(bb);
    case (op)
      5'd0: begin
        s = aa + bb + {63'h0, ci};
        r = 32'(s & m);
        c = s[w];
        v = (aa[msb] == bb[msb]) && (r[msb] != aa[msb]);
      end
      5'd1: begin
        s = aa + (~bb & m) + 64'd1;
        r = 32'(s & m);
        c = s[w];
        v = (aa[msb] != bb[msb]) && (r[msb] != aa[msb]);
      end
      5'd2:  r = 32'(aa & bb);
      5'd3:  r = 32'(aa | bb);
      5'd4:  r = 32'(aa ^ bb);
      5'd5:  r = 32'((aa << sh) & m);
      5'd6:  r = 32'(aa >> sh);
      5'd7:  r = 32'((aa >> sh) | (aa[msb] ? (m & ~(m >> sh)) : 64'd0));
      5'd8:  r = 32'(((aa << sh) | (aa >> (w - int'(sh)))) & m);
      5'd9:  r = 32'(((aa >> sh) | (aa << (w - int'(sh)))) & m);
      5'd10: r = (sa < sb) ? 32'd1 : 32'd0;
      5'd11: r = (aa < bb) ? 32'd1 : 32'd0;
      5'd12: begin
        r = 32'(p & m);
        v = ((p >> w) & m) != 64'd0;
      end
      5'd13: r = 32'((p >> w) & m);
      default: r = 32'h0;
    endcase
    return {r, c, v, (r == 32'h0)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sbStep();
    exp_t got;
    if (bus32.out_valid && bus32.out_ready) begin
      got = {bus32.result, bus32.carryout, bus32.overflow, bus32.zero};
      if (q32.size() == 0) checkOutput("out32 unexpected", got, 64'hDEAD);
      else checkOutput("out32", got, q32.pop_front());
    end
    if (bus8.out_valid && bus8.out_ready) begin
      got = {24'h0, bus8.result, bus8.carryout, bus8.overflow, bus8.zero};
      if (q8.size() == 0) checkOutput("out8 unexpected", got, 64'hDEAD);
      else checkOutput("out8", got, q8.pop_front());
    end
    if (bus32.in_valid && bus32.in_ready) begin
      q32.push_back(pend32);
      acc32 = 1'b1;
    end
    if (bus8.in_valid && bus8.in_ready) begin
      q8.push_back(pend8);
      acc8 = 1'b1;
    end
    if (flush32) q32.delete();
    if (flush8)  q8.delete();
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    #1;
    sbStep();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int sel, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic ci, input logic [4:0] sh,
                               input exp_t e);
    logic got_it;
    if (sel == 0) begin
      bus32.opcode = op; bus32.A = a; bus32.B = b; bus32.cin = ci; bus32.shamt = sh;
      pend32 = e; acc32 = 1'b0; bus32.in_valid = 1'b1;
    end else begin
      bus8.opcode = op; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.cin = ci; bus8.shamt = sh[2:0];
      pend8 = e; acc8 = 1'b0; bus8.in_valid = 1'b1;
    end
    got_it = 1'b0;
    for (int i = 0; i < 64 && !got_it; i++) begin
      tick();
      got_it = (sel == 0) ? acc32 : acc8;
    end
    checkOutput("accepted", got_it, 1);
    bus32.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
  endtask

  task automatic drainAll();
    bus32.out_ready = 1'b1;
    bus8.out_ready  = 1'b1;
    for (int i = 0; i < 100 && (q32.size() + q8.size()) != 0; i++) tick();
    checkOutput("drain", q32.size() + q8.size(), 0);
  endtask

  task automatic randBundle(input int sel);
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        ci;
    logic [4:0]  sh;
    op = 5'($urandom_range(0, 15));
    a  = $urandom;
    b  = $urandom;
    if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
    ci = 1'($urandom_range(0, 1));
    sh = 5'($urandom_range(0, (sel == 0) ? 31 : 7));
    if (sel == 0) begin
      bus32.opcode = op; bus32.A = a; bus32.B = b; bus32.cin = ci; bus32.shamt = sh;
      pend32 = refModel(32, op, a, b, ci, sh); bus32.in_valid = 1'b1;
    end else begin
      bus8.opcode = op; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.cin = ci; bus8.shamt = sh[2:0];
      pend8 = refModel(8, op, a, b, ci, sh); bus8.in_valid = 1'b1;
    end
  endtask

  task automatic addVec(input int sel, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [4:0] sh, input exp_t e);
    vec_t t;
    t.sel = sel; t.op = op; t.a = a; t.b = b; t.ci = ci; t.sh = sh; t.e = e;
    tv.push_back(t);
  endtask

  initial begin
    int cnt, n32, n8;

    addVec(0, 5'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 5'd0,  mk(32'h00000000, 1, 0, 1));
    addVec(0, 5'd0,  32'h40000000, 32'h40000000, 1'b0, 5'd0,  mk(32'h80000000, 0, 1, 0));
    addVec(0, 5'd0,  32'h00000005, 32'h00000007, 1'b1, 5'd0,  mk(32'h0000000D, 0, 0, 0));
    addVec(0, 5'd1,  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd0,  mk(32'h80000000, 0, 1, 0));
    addVec(0, 5'd1,  32'd20,       32'd5,        1'b0, 5'd0,  mk(32'd15,        1, 0, 0));
    addVec(0, 5'd4,  32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 5'd0,  mk(32'hF00FF00F, 0, 0, 0));
    addVec(0, 5'd5,  32'h00000001, 32'h0,        1'b0, 5'd31, mk(32'h80000000, 0, 0, 0));
    addVec(0, 5'd6,  32'h80000000, 32'h0,        1'b0, 5'd31, mk(32'h00000001, 0, 0, 0));
    addVec(0, 5'd8,  32'h80000001, 32'h0,        1'b0, 5'd4,  mk(32'h00000018, 0, 0, 0));
    addVec(0, 5'd9,  32'h12345678, 32'h0,        1'b0, 5'd0,  mk(32'h12345678, 0, 0, 0));
    addVec(0, 5'd10, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5'd0,  mk(32'h00000001, 0, 0, 0));
    addVec(0, 5'd11, 32'h00000001, 32'hFFFFFFFF, 1'b0, 5'd0,  mk(32'h00000001, 0, 0, 0));
    addVec(0, 5'd20, 32'h00000123, 32'h00000123, 1'b1, 5'd3,  mk(32'h00000000, 0, 0, 1));
    addVec(0, 5'd12, 32'h00010000, 32'h00010000, 1'b0, 5'd0,  mk(32'h00000000, 0, 1, 1));
    addVec(0, 5'd13, 32'h00010000, 32'h00010000, 1'b0, 5'd0,  mk(32'h00000001, 0, 0, 0));
    addVec(1, 5'd9,  32'h81,       32'h0,        1'b0, 5'd1,  mk(32'hC0,        0, 0, 0));
    addVec(1, 5'd7,  32'h80,       32'h0,        1'b0, 5'd7,  mk(32'hFF,        0, 0, 0));
    addVec(1, 5'd11, 32'hFF,       32'h01,       1'b0, 5'd0,  mk(32'h00,        0, 0, 1));
    addVec(1, 5'd10, 32'hFF,       32'h01,       1'b0, 5'd0,  mk(32'h01,        0, 0, 0));
    addVec(1, 5'd0,  32'h7F,       32'h01,       1'b0, 5'd0,  mk(32'h80,        0, 1, 0));
    addVec(1, 5'd1,  32'h00,       32'h01,       1'b0, 5'd0,  mk(32'hFF,        0, 0, 0));
    addVec(1, 5'd12, 32'hFF,       32'hFF,       1'b0, 5'd0,  mk(32'h01,        0, 1, 0));
    addVec(1, 5'd13, 32'hFF,       32'hFF,       1'b0, 5'd0,  mk(32'hFE,        0, 0, 0));

    rst_n = 1'b0; flush32 = 1'b0; flush8 = 1'b0; acc32 = 1'b0; acc8 = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.opcode = 5'd0;
    bus32.A = '0; bus32.B = '0; bus32.cin = 1'b0; bus32.shamt = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.opcode = 5'd0;
    bus8.A = '0; bus8.B = '0; bus8.cin = 1'b0; bus8.shamt = '0;
    pend32 = '0; pend8 = '0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset32 outputs", {bus32.out_valid, bus32.busy, bus32.carryout, bus32.overflow,
                                    bus32.zero, bus32.result}, 0);
    checkOutput("reset8 outputs", {bus8.out_valid, bus8.busy, bus8.carryout, bus8.overflow,
                                   bus8.zero, bus8.result}, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("in_ready after reset", {bus32.in_ready, bus8.in_ready}, 2'b11);

    $display("[TB] directed vectors");
    foreach (tv[i]) begin
      applyStimulus(tv[i].sel, tv[i].op, tv[i].a, tv[i].b, tv[i].ci, tv[i].sh, tv[i].e);
      drainAll();
    end

    $display("[TB] multiplier occupancy");
    applyStimulus(0, 5'd12, 32'h00010000, 32'h00010000, 1'b0, 5'd0, mk(32'h0, 0, 1, 1));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus32.out_valid) break;
      if (bus32.busy && !bus32.in_ready) cnt++;
      tick();
    end
    checkOutput("mul busy cycles", cnt, 32);
    checkOutput("mul done out_valid", {bus32.out_valid, bus32.busy}, 2'b10);
    drainAll();

    $display("[TB] back-pressure");
    bus32.out_ready = 1'b0;
    applyStimulus(0, 5'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 5'd0, mk(32'h05050505, 0, 0, 0));
    bus32.opcode = 5'd3; bus32.A = 32'h1; bus32.B = 32'h2; bus32.cin = 1'b0; bus32.shamt = '0;
    pend32 = mk(32'h3, 0, 0, 0); acc32 = 1'b0; bus32.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("held result", bus32.result, 32'h05050505);
      checkOutput("held valid/ready", {bus32.out_valid, bus32.in_ready}, 2'b10);
      tick();
    end
    checkOutput("no accept under hold", acc32, 0);
    bus32.out_ready = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    checkOutput("drain+accept same edge", {acc32, bus32.out_valid}, 2'b11);
    drainAll();

    $display("[TB] flush mid-multiply");
    applyStimulus(0, 5'd12, 32'h00000003, 32'h00000005, 1'b0, 5'd0, mk(32'hF, 0, 0, 0));
    for (int i = 0; i < 9; i++) tick();
    flush32 = 1'b1;
    tick();
    flush32 = 1'b0;
    #1;
    checkOutput("after flush", {bus32.busy, bus32.in_ready, bus32.out_valid}, 3'b010);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus32.out_valid) cnt++;
      tick();
    end
    checkOutput("flushed op never valid", cnt, 0);

    $display("[TB] reset mid-multiply");
    applyStimulus(0, 5'd0, 32'h1, 32'h2, 1'b0, 5'd0, mk(32'h3, 0, 0, 0));
    drainAll();
    applyStimulus(0, 5'd12, 32'h00000003, 32'h00000005, 1'b0, 5'd0, mk(32'hF, 0, 0, 0));
    for (int i = 0; i < 9; i++) tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset32", {bus32.out_valid, bus32.busy, bus32.carryout, bus32.overflow,
                                  bus32.zero, bus32.result}, 0);
    q32.delete();
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("in_ready after pulse", bus32.in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus32.out_valid) cnt++;
      tick();
    end
    checkOutput("reset op never valid", cnt, 0);

    $display("[TB] random bundles");
    n32 = 0; n8 = 0; acc32 = 1'b0; acc8 = 1'b0;
    for (int cyc = 0; cyc < 30000 && (n32 < 500 || n8 < 500); cyc++) begin
      if (acc32) begin n32++; acc32 = 1'b0; bus32.in_valid = 1'b0; end
      if (acc8)  begin n8++;  acc8  = 1'b0; bus8.in_valid  = 1'b0; end
      if (!bus32.in_valid && n32 < 500 && $urandom_range(0, 3) != 0) randBundle(0);
      if (!bus8.in_valid  && n8  < 500 && $urandom_range(0, 3) != 0) randBundle(1);
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      bus8.out_ready  = ($urandom_range(0, 3) != 0);
      flush32 = ($urandom_range(0, 99) == 0);
      flush8  = ($urandom_range(0, 99) == 0);
      tick();
    end
    if (acc32) n32++;
    if (acc8)  n8++;
    flush32 = 1'b0; flush8 = 1'b0;
    bus32.in_valid = 1'b0; bus8.in_valid = 1'b0;
    checkOutput("random accepted 32", n32, 500);
    checkOutput("random accepted 8", n8, 500);
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
